triple_mul_engine: RTL and testbench
====================================

// Module: triple_mul_engine
// PURPOSE
//  Sequential signed multiply engine: D = A*B*C, 8-bit two's-comp operands, 24-bit two's-comp product.
//  Sits beside the core datapath as its multiply stage; core supplies operands, engine returns product.
//  Optionally writes the product into data memory as 3 little-endian bytes at RESULT_BASE..+2 (LSB first).
//  Uses the program's start/done handshake: falling edge of start launches, done acknowledges.
// PARAMETERS
//  RESULT_BASE  3  byte address of the product LSB in data memory (MSB at RESULT_BASE+2)
//  ADDR_W       8  data-memory byte-address width
// PORTS
//  clk        in   1       single clock; all logic on the rising edge
//  reset      in   1       synchronous, active-low (0 = reset); sampled on clk only
//  start      in   1       request; the 1->0 transition launches an operation
//  op_a       in   8       signed operand A; sampled in LOAD
//  op_b       in   8       signed operand B; sampled in LOAD
//  op_c       in   8       signed operand C; sampled in LOAD
//  prod       out  24      signed product; valid while done=1
//  busy       out  1       1 from LOAD through the last WB/SIGN cycle
//  done       out  1       acknowledge; holds 1 until start returns to 1
//  mem_we     out  1       byte write strobe (only with TMUL_WRITEBACK_EN)
//  mem_addr   out  ADDR_W  byte write address
//  mem_wdata  out  8       byte write data
// BEHAVIOUR
//  Reset (reset=0 at an edge): state=IDLE; prod=0, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
//    start_q is loaded with 1, so a start already low on exit from reset is not a trigger.
//  Trigger: start_q==1 && start==0 in IDLE; start_q<=start every cycle. Falling edges outside IDLE are ignored.
//  States: IDLE -> LOAD -> MUL1 (8 cyc) -> MUL2 (8 cyc) -> SIGN -> [WB0 -> WB1 -> WB2] -> DONE -> IDLE.
//  LOAD: latch |A|,|B|,|C| as 8-bit unsigned (|-128| = 128); neg = sA^sB^sC; a zero operand does not change the path.
//  MUL1: unsigned shift-add of |A|*|B| -> 16-bit magnitude m1; one multiplier bit per cycle, LSB first.
//  MUL2: unsigned shift-add of m1*|C| -> 24-bit magnitude m2; one bit per cycle. Bit counter is 3 bits, clears per phase.
//  SIGN: prod <= neg ? -m2 : m2, at 24 bits; -0 gives 0. |product| <= 2^21, so no overflow and no saturation.
//  Latency: trigger sampled at edge 0 -> LOAD; done=1 after edge 18 (no WB) or edge 21 (WB); fixed, independent of data.
//  DONE: done=1, busy=0, prod held. When start samples 1 -> IDLE, done=0 on the next edge; prod holds its value.
//  Start rising mid-operation: ignored; the operation completes and done goes high only for 1 cycle if start is already 1.
//  Reset mid-operation: immediate return to IDLE, no further mem_we pulses, partial product discarded.
//  Operand changes after LOAD: no effect on the result.
// CONFIGURATION
//  TMUL_WRITEBACK_EN defined: after SIGN, WB0..WB2 each pulse mem_we=1 for one cycle:
//    WB0 addr=RESULT_BASE data=prod[7:0]; WB1 +1 prod[15:8]; WB2 +2 prod[23:16]; then DONE.
//  TMUL_WRITEBACK_EN undefined: no WB states; SIGN -> DONE; mem_we, mem_addr and mem_wdata are tied to 0.
// TESTING
//  T1 A=2,B=4,C=8, start 1->0 -> done at edge 18/21; prod=0x000040; WB bytes [3]=40,[4]=00,[5]=00.
//  T2 A=B=C=-128 -> prod=0xE00000 (-2097152); WB bytes 00,00,E0.
//  T3 A=-1,B=127,C=2 -> prod=0xFFFF02 (-254); A=0,B=-5,C=9 -> prod=0x000000, latency unchanged.
//  T4 reset=0 at edge 10 of an op -> next edge: busy=0, done=0, prod=0; no mem_we afterward; a new start works.
//  T5 hold start=0 after done -> done stays 1, no relaunch; start=1 -> done=0 next edge; a new 1->0 launches again.
//  T6 second falling start while busy -> ignored; exactly 3 mem_we pulses per op (WB build), 0 otherwise.

Source files
------------

// File: rtl/triple_mul_engine.sv
// Sequential signed triple multiplier D = A*B*C (8-bit operands, 24-bit product) with falling-edge start.
// Define TMUL_WRITEBACK_EN to add the three-byte little-endian product write to data memory.
module triple_mul_engine #(
  parameter int RESULT_BASE = 3,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        op_a,
  input  logic [7:0]        op_b,
  input  logic [7:0]        op_c,
  output logic [23:0]       prod,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

`ifdef TMUL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_MUL1, S_MUL2, S_SIGN, S_WB0, S_WB1, S_WB2, S_DONE
  } state_t;

  state_t      state, nxt;
  logic        start_q;
  logic [7:0]  mag_a, mag_b, mag_c;
  logic        neg;
  logic [2:0]  cnt;
  logic [15:0] m1;
  logic [23:0] m2;

  function automatic logic [7:0] mag(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  // start_q resets high so only a genuine 1->0 edge after reset can launch
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      start_q <= 1'b1;
    end else begin
      state   <= nxt;
      start_q <= start;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start_q && !start) nxt = S_LOAD;
      S_LOAD: nxt = S_MUL1;
      S_MUL1: if (cnt == 3'd7) nxt = S_MUL2;
      S_MUL2: if (cnt == 3'd7) nxt = S_SIGN;
`ifdef TMUL_WRITEBACK_EN
      S_SIGN: nxt = S_WB0;
`else
      S_SIGN: nxt = S_DONE;
`endif
      S_WB0:  nxt = S_WB1;
      S_WB1:  nxt = S_WB2;
      S_WB2:  nxt = S_DONE;
      S_DONE: if (start) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Magnitude datapath; cnt wraps 7->0 at the end of MUL1, clearing it for MUL2
  always_ff @(posedge clk) begin
    if (!reset) begin
      mag_a <= '0;
      mag_b <= '0;
      mag_c <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      m1    <= '0;
      m2    <= '0;
      prod  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          mag_a <= mag(op_a);
          mag_b <= mag(op_b);
          mag_c <= mag(op_c);
          neg   <= op_a[7] ^ op_b[7] ^ op_c[7];
          cnt   <= '0;
          m1    <= '0;
          m2    <= '0;
        end
        S_MUL1: begin
          if (mag_b[cnt]) m1 <= m1 + (16'(mag_a) << cnt);
          cnt <= cnt + 3'd1;
        end
        S_MUL2: begin
          if (mag_c[cnt]) m2 <= m2 + (24'(m1) << cnt);
          cnt <= cnt + 3'd1;
        end
        S_SIGN: prod <= neg ? (~m2 + 24'd1) : m2;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_LOAD, S_MUL1, S_MUL2, S_SIGN: busy = 1'b1;
      S_WB0: begin
        busy = 1'b1;
        if (WB_EN) begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(RESULT_BASE);
          mem_wdata = prod[7:0];
        end
      end
      S_WB1: begin
        busy = 1'b1;
        if (WB_EN) begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(RESULT_BASE + 1);
          mem_wdata = prod[15:8];
        end
      end
      S_WB2: begin
        busy = 1'b1;
        if (WB_EN) begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(RESULT_BASE + 2);
          mem_wdata = prod[23:16];
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_triple_mul_engine.sv
// Randomized self-checking bench for triple_mul_engine against a cycle-timeline reference model.
module tb_triple_mul_engine;
`ifdef TMUL_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam int LAT  = WB ? 21 : 18;
  localparam int BASE = 3;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b1;
  logic [7:0]  op_a = '0, op_b = '0, op_c = '0;
  logic [23:0] prod;
  logic        busy, done, mem_we;
  logic [7:0]  mem_addr, mem_wdata;

  triple_mul_engine #(.RESULT_BASE(BASE), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .prod(prod), .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, we_cnt = 0;
  logic [7:0] wmem [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic [23:0] ref_prod(input logic signed [7:0] a, b, c);
    int p;
    p = int'(a) * int'(b) * int'(c);
    return 24'(p);
  endfunction

  // Reference model: tracks edges since the trigger edge, result appears at edge 18
  logic              m_act = 1'b0, m_done = 1'b0, m_sq = 1'b1;
  int                m_k = 0;
  logic [23:0]       m_prod = '0;
  logic signed [7:0] la = '0, lb = '0, lc = '0;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_act = 1'b0; m_done = 1'b0; m_sq = 1'b1; m_prod = '0;
    end else begin
      if (m_done) begin
        if (start) m_done = 1'b0;
      end else if (m_act) begin
        m_k++;
        if (m_k == 1) begin la = op_a; lb = op_b; lc = op_c; end
        if (m_k == 18) m_prod = ref_prod(la, lb, lc);
        if (m_k == LAT) begin m_act = 1'b0; m_done = 1'b1; end
      end else if (m_sq && !start) begin
        m_act = 1'b1; m_k = 0;
      end
      m_sq = start;
    end
  end

  initial forever begin
    logic       e_we;
    logic [7:0] e_addr, e_data;
    @(negedge clk);
    e_we   = WB && m_act && m_k >= 18 && m_k <= 20;
    e_addr = e_we ? 8'(BASE + m_k - 18) : 8'h00;
    e_data = 8'h00;
    if (e_we) e_data = 8'(m_prod >> (8 * (m_k - 18)));
    chk("busy", busy, m_act);
    chk("done", done, m_done);
    chk("prod", prod, m_prod);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_data);
    if (mem_we) begin wmem[mem_addr] = mem_wdata; we_cnt++; end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 2) begin op_a = 8'($urandom); op_b = 8'($urandom); op_c = 8'($urandom); end
    end
  endtask

  task automatic run_op(input logic [7:0] a, b, c, input logic [23:0] exp, input string tag);
    int n;
    op_a = a; op_b = b; op_c = c;
    wmem[BASE] = 8'hAA; wmem[BASE+1] = 8'hAA; wmem[BASE+2] = 8'hAA;
    we_cnt = 0;
    start = 1'b0;
    wait_done(n);
    chk({tag, "_latency"}, n, LAT + 1);
    chk({tag, "_prod"}, prod, exp);
    chk({tag, "_wb0"}, wmem[BASE],   WB ? exp[7:0]   : 8'hAA);
    chk({tag, "_wb1"}, wmem[BASE+1], WB ? exp[15:8]  : 8'hAA);
    chk({tag, "_wb2"}, wmem[BASE+2], WB ? exp[23:16] : 8'hAA);
    chk({tag, "_we_pulses"}, we_cnt, WB ? 3 : 0);
    start = 1'b1;
    cyc(1);
    chk({tag, "_done_clr"}, done, 1'b0);
    cyc(1);
  endtask

  initial begin
    int n;
    logic [7:0] a, b, c;
    // pin the reference model with hand-computed products
    chk("model_t1", ref_prod(8'd2, 8'd4, 8'd8), 24'h000040);
    chk("model_t2", ref_prod(8'h80, 8'h80, 8'h80), 24'hE00000);
    chk("model_t3", ref_prod(8'hFF, 8'd127, 8'd2), 24'hFFFF02);

    cyc(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", prod, 24'h0);
    chk("rst_we", mem_we, 1'b0);
    reset = 1'b1;
    cyc(2);

    run_op(8'd2, 8'd4, 8'd8, 24'h000040, "t1");
    run_op(8'h80, 8'h80, 8'h80, 24'hE00000, "t2");
    run_op(8'hFF, 8'd127, 8'd2, 24'hFFFF02, "t3a");
    run_op(8'd0, 8'hFB, 8'd9, 24'h000000, "t3b");

    // T4: reset lands on edge 10 of an operation
    op_a = 8'd7; op_b = 8'd9; op_c = 8'd11;
    we_cnt = 0;
    start = 1'b0;
    cyc(10);
    reset = 1'b0;
    cyc(1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_prod", prod, 24'h0);
    start = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(30);
    chk("t4_no_we", we_cnt, 0);
    run_op(8'd3, 8'hFD, 8'd5, 24'hFFFFD3, "t4_new");

    // T5: hold start low after done
    op_a = 8'd5; op_b = 8'd6; op_c = 8'd7;
    start = 1'b0;
    wait_done(n);
    chk("t5_latency", n, LAT + 1);
    cyc(8);
    chk("t5_hold_done", done, 1'b1);
    chk("t5_hold_busy", busy, 1'b0);
    chk("t5_prod", prod, 24'd210);
    start = 1'b1;
    cyc(1);
    chk("t5_done_clr", done, 1'b0);
    cyc(1);
    run_op(8'hF6, 8'd10, 8'd10, 24'hFFFC18, "t5_relaunch");

    // T6: extra start edges during an operation, start already high at completion
    op_a = 8'd127; op_b = 8'd127; op_c = 8'd127;
    we_cnt = 0;
    start = 1'b0;
    cyc(5);  start = 1'b1;
    cyc(2);  start = 1'b0;
    cyc(2);  start = 1'b1;
    cyc(LAT + 5);
    chk("t6_we_pulses", we_cnt, WB ? 3 : 0);
    chk("t6_prod", prod, 24'h1F417F);
    chk("t6_idle", busy, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      if (i % 7 == 0) a = 8'h80;
      if (i % 11 == 3) c = 8'h00;
      run_op(a, b, c, ref_prod(a, b, c), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
